// File: rtl/pmem_arbiter.sv
// Arbitrates the single cacheline-adapter port between I-cache and D-cache, one transfer at a time.
// Optional build macro ARB_ROUND_ROBIN_EN: simultaneous requests alternate instead of favouring D.
module pmem_arbiter #(
    parameter int unsigned s_line = 256,
    parameter int unsigned s_addr = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [s_addr-1:0] i_pmem_address,
    output logic [s_line-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [s_addr-1:0] d_pmem_address,
    input  logic [s_line-1:0] d_pmem_wdata,
    output logic [s_line-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [s_addr-1:0] pmem_address,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;
    state_t w_tie_state;
    logic   w_i_req;
    logic   w_d_req;

    assign w_i_req = i_pmem_read;
    assign w_d_req = d_pmem_read | d_pmem_write;

    // Read data is broadcast; only the resp pulse identifies the owner.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

`ifdef ARB_ROUND_ROBIN_EN
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    grant_t r_last_grant;

    // Remembers who completed most recently so ties alternate.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_grant <= GRANT_I;
        end else if (pmem_resp && (r_state == SERVE_I)) begin
            r_last_grant <= GRANT_I;
        end else if (pmem_resp && (r_state == SERVE_D)) begin
            r_last_grant <= GRANT_D;
        end
    end

    assign w_tie_state = (r_last_grant == GRANT_I) ? SERVE_D : SERVE_I;
`else
    assign w_tie_state = SERVE_D;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and pmem/resp steering; a completing resp takes precedence over an abort.
    always_comb begin
        w_next_state = r_state;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_i_req && w_d_req) begin
                    w_next_state = w_tie_state;
                end else if (w_d_req) begin
                    w_next_state = SERVE_D;
                end else if (w_i_req) begin
                    w_next_state = SERVE_I;
                end
            end
            SERVE_I: begin
                pmem_read    = i_pmem_read;
                pmem_address = i_pmem_address;
                if (pmem_resp) begin
                    i_pmem_resp  = 1'b1;
                    w_next_state = IDLE;
                end else if (!w_i_req) begin
                    w_next_state = IDLE;
                end
            end
            SERVE_D: begin
                pmem_read    = d_pmem_read & ~d_pmem_write;
                pmem_write   = d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                if (pmem_resp) begin
                    d_pmem_resp  = 1'b1;
                    w_next_state = IDLE;
                end else if (!w_d_req) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: one task per scenario, inline checks against hand-computed values.
module tb_pmem_arbiter;

    localparam logic [255:0] DATA_A5 = {32{8'hA5}};
    localparam logic [255:0] DATA_WB = {8{32'h12345678}};
    localparam logic [255:0] DATA_5A = {32{8'h5A}};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_pmem_read = 1'b0;
    logic [31:0]  i_pmem_address = '0;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read = 1'b0;
    logic         d_pmem_write = 1'b0;
    logic [31:0]  d_pmem_address = '0;
    logic [255:0] d_pmem_wdata = '0;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pmem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    // Inputs change on the falling edge; outputs are checked 1 time unit later.
    task automatic drop_all();
        i_pmem_read  = 1'b0;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        pmem_resp    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_pmem_read = 1'b1;
        d_pmem_write = 1'b1;
        d_pmem_wdata = DATA_WB;
        repeat (2) @(negedge clk);
        #1;
        total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL reset_read got=%0h exp=0", pmem_read); end
        total++; if (pmem_write !== 1'b0) begin bad++; $display("FAIL reset_write got=%0h exp=0", pmem_write); end
        total++; if (pmem_address !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", pmem_address); end
        total++; if (pmem_wdata !== 256'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", pmem_wdata); end
        total++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin bad++; $display("FAIL reset_resp got=%b exp=00", {i_pmem_resp, d_pmem_resp}); end
        @(negedge clk);
        drop_all();
        d_pmem_wdata = '0;
        rst = 1'b1;
    endtask

    task automatic test_tie();
        logic        first_is_d;
        logic [31:0] first_addr;
        logic [31:0] second_addr;
`ifdef ARB_ROUND_ROBIN_EN
        first_is_d = 1'b0; first_addr = 32'h100; second_addr = 32'h300;
`else
        first_is_d = 1'b1; first_addr = 32'h300; second_addr = 32'h100;
`endif
        @(negedge clk);
        i_pmem_read = 1'b1; i_pmem_address = 32'h100;
        d_pmem_read = 1'b1; d_pmem_address = 32'h200;
        #1;
        total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL tie_latency got=%0h exp=0", pmem_read); end
        @(negedge clk);
        #1;
        total++; if (pmem_address !== 32'h200 || pmem_read !== 1'b1) begin bad++; $display("FAIL tie_first_d got=%h/%0h exp=200/1", pmem_address, pmem_read); end
        pmem_rdata = DATA_5A; pmem_resp = 1'b1;
        #1;
        total++; if ({i_pmem_resp, d_pmem_resp} !== 2'b01) begin bad++; $display("FAIL tie_d_resp got=%b exp=01", {i_pmem_resp, d_pmem_resp}); end
        total++; if (d_pmem_rdata !== DATA_5A) begin bad++; $display("FAIL tie_d_rdata got=%h exp=%h", d_pmem_rdata, DATA_5A); end
        // D re-requests a new line during the gap cycle, creating a second tie.
        @(negedge clk);
        pmem_resp = 1'b0; d_pmem_address = 32'h300;
        #1;
        total++; if (pmem_read !== 1'b0 || d_pmem_resp !== 1'b0) begin bad++; $display("FAIL tie_gap got=%0h/%0h exp=0/0", pmem_read, d_pmem_resp); end
        @(negedge clk);
        #1;
        total++; if (pmem_address !== first_addr || pmem_read !== 1'b1) begin bad++; $display("FAIL tie_repeat_first got=%h/%0h exp=%h/1", pmem_address, pmem_read, first_addr); end
        pmem_resp = 1'b1;
        #1;
        total++; if ({i_pmem_resp, d_pmem_resp} !== {~first_is_d, first_is_d}) begin bad++; $display("FAIL tie_repeat_resp1 got=%b exp=%b", {i_pmem_resp, d_pmem_resp}, {~first_is_d, first_is_d}); end
        @(negedge clk);
        pmem_resp = 1'b0;
        if (first_is_d) d_pmem_read = 1'b0; else i_pmem_read = 1'b0;
        #1;
        total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL tie_gap2 got=%0h exp=0", pmem_read); end
        @(negedge clk);
        #1;
        total++; if (pmem_address !== second_addr || pmem_read !== 1'b1) begin bad++; $display("FAIL tie_second got=%h/%0h exp=%h/1", pmem_address, pmem_read, second_addr); end
        pmem_resp = 1'b1;
        #1;
        total++; if ({i_pmem_resp, d_pmem_resp} !== {first_is_d, ~first_is_d}) begin bad++; $display("FAIL tie_repeat_resp2 got=%b exp=%b", {i_pmem_resp, d_pmem_resp}, {first_is_d, ~first_is_d}); end
        @(negedge clk);
        drop_all();
    endtask

    task automatic test_i_read();
        @(negedge clk);
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1040;
        #1;
        total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL iread_latency got=%0h exp=0", pmem_read); end
        @(negedge clk);
        #1;
        total++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin bad++; $display("FAIL iread_req got=%0h%0h exp=10", pmem_read, pmem_write); end
        total++; if (pmem_address !== 32'h0000_1040) begin bad++; $display("FAIL iread_addr got=%h exp=00001040", pmem_address); end
        total++; if (pmem_wdata !== 256'h0) begin bad++; $display("FAIL iread_wdata got=%h exp=0", pmem_wdata); end
        pmem_rdata = DATA_A5; pmem_resp = 1'b1;
        #1;
        total++; if ({i_pmem_resp, d_pmem_resp} !== 2'b10) begin bad++; $display("FAIL iread_resp got=%b exp=10", {i_pmem_resp, d_pmem_resp}); end
        total++; if (i_pmem_rdata !== DATA_A5) begin bad++; $display("FAIL iread_rdata got=%h exp=%h", i_pmem_rdata, DATA_A5); end
        @(negedge clk);
        drop_all();
        #1;
        total++; if (pmem_read !== 1'b0 || i_pmem_resp !== 1'b0) begin bad++; $display("FAIL iread_done got=%0h/%0h exp=0/0", pmem_read, i_pmem_resp); end
    endtask

    task automatic test_d_write();
        int pulses;
        @(negedge clk);
        d_pmem_write = 1'b1; d_pmem_address = 32'h0000_2060; d_pmem_wdata = DATA_WB;
        pulses = 0;
        @(negedge clk);
        #1;
        total++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin bad++; $display("FAIL dwr_req got=%0h%0h exp=01", pmem_read, pmem_write); end
        total++; if (pmem_address !== 32'h0000_2060) begin bad++; $display("FAIL dwr_addr got=%h exp=00002060", pmem_address); end
        total++; if (pmem_wdata !== DATA_WB) begin bad++; $display("FAIL dwr_wdata got=%h exp=%h", pmem_wdata, DATA_WB); end
        for (int k = 0; k < 10; k++) begin
            if (d_pmem_resp === 1'b1) pulses++;
            @(negedge clk);
            #1;
        end
        pmem_resp = 1'b1;
        #1;
        if (d_pmem_resp === 1'b1) pulses++;
        total++; if (i_pmem_resp !== 1'b0) begin bad++; $display("FAIL dwr_iresp got=%0h exp=0", i_pmem_resp); end
        @(negedge clk);
        drop_all();
        #1;
        if (d_pmem_resp === 1'b1) pulses++;
        total++; if (pulses != 1) begin bad++; $display("FAIL dwr_pulses got=%0d exp=1", pulses); end
        total++; if (pmem_write !== 1'b0) begin bad++; $display("FAIL dwr_done got=%0h exp=0", pmem_write); end
    endtask

    task automatic test_mid_transfer();
        @(negedge clk);
        i_pmem_read = 1'b1; i_pmem_address = 32'h400;
        @(negedge clk);
        d_pmem_read = 1'b1; d_pmem_address = 32'h500;
        #1;
        total++; if (pmem_address !== 32'h400) begin bad++; $display("FAIL mid_hold0 got=%h exp=400", pmem_address); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            total++; if (pmem_address !== 32'h400 || pmem_read !== 1'b1) begin bad++; $display("FAIL mid_hold got=%h/%0h exp=400/1", pmem_address, pmem_read); end
        end
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        total++; if ({i_pmem_resp, d_pmem_resp} !== 2'b10) begin bad++; $display("FAIL mid_iresp got=%b exp=10", {i_pmem_resp, d_pmem_resp}); end
        @(negedge clk);
        pmem_resp = 1'b0; i_pmem_read = 1'b0;
        #1;
        total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL mid_gap got=%0h exp=0", pmem_read); end
        @(negedge clk);
        #1;
        total++; if (pmem_address !== 32'h500 || pmem_read !== 1'b1) begin bad++; $display("FAIL mid_dgrant got=%h/%0h exp=500/1", pmem_address, pmem_read); end
        pmem_resp = 1'b1;
        #1;
        total++; if ({i_pmem_resp, d_pmem_resp} !== 2'b01) begin bad++; $display("FAIL mid_dresp got=%b exp=01", {i_pmem_resp, d_pmem_resp}); end
        @(negedge clk);
        drop_all();
    endtask

    task automatic test_rw_both();
        @(negedge clk);
        d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 32'h900; d_pmem_wdata = DATA_5A;
        @(negedge clk);
        #1;
        total++; if ({pmem_read, pmem_write} !== 2'b01) begin bad++; $display("FAIL rw_as_write got=%b exp=01", {pmem_read, pmem_write}); end
        total++; if (pmem_wdata !== DATA_5A) begin bad++; $display("FAIL rw_wdata got=%h exp=%h", pmem_wdata, DATA_5A); end
        pmem_resp = 1'b1;
        @(negedge clk);
        drop_all();
    endtask

    task automatic test_abort();
        @(negedge clk);
        i_pmem_read = 1'b1; i_pmem_address = 32'h800;
        @(negedge clk);
        i_pmem_read = 1'b0;
        #1;
        total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL abort_drop got=%0h exp=0", pmem_read); end
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        total++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin bad++; $display("FAIL abort_resp got=%b exp=00", {i_pmem_resp, d_pmem_resp}); end
        @(negedge clk);
        drop_all();
    endtask

    task automatic test_spurious();
        @(negedge clk);
        pmem_rdata = DATA_WB; pmem_resp = 1'b1;
        #1;
        total++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin bad++; $display("FAIL spur_resp got=%b exp=00", {i_pmem_resp, d_pmem_resp}); end
        total++; if (i_pmem_rdata !== DATA_WB || d_pmem_rdata !== DATA_WB) begin bad++; $display("FAIL spur_rdata got=%h exp=%h", d_pmem_rdata, DATA_WB); end
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        total++; if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin bad++; $display("FAIL spur_idle got=%b exp=0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        d_pmem_read = 1'b1; d_pmem_address = 32'h600;
        @(negedge clk);
        #1;
        total++; if (pmem_read !== 1'b1 || pmem_address !== 32'h600) begin bad++; $display("FAIL rstmid_serve got=%0h/%h exp=1/600", pmem_read, pmem_address); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        total++; if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin bad++; $display("FAIL rstmid_clear got=%b exp=0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}); end
        rst = 1'b1; d_pmem_read = 1'b0;
        i_pmem_read = 1'b1; i_pmem_address = 32'h700;
        @(negedge clk);
        #1;
        total++; if (pmem_read !== 1'b1 || pmem_address !== 32'h700) begin bad++; $display("FAIL rstmid_after got=%0h/%h exp=1/700", pmem_read, pmem_address); end
        pmem_resp = 1'b1;
        #1;
        total++; if ({i_pmem_resp, d_pmem_resp} !== 2'b10) begin bad++; $display("FAIL rstmid_iresp got=%b exp=10", {i_pmem_resp, d_pmem_resp}); end
        @(negedge clk);
        drop_all();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_i_read();
        test_d_write();
        test_mid_transfer();
        test_rw_both();
        test_abort();
        test_spurious();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
